// File: rtl/master_req_ctrl.sv
// Per-master request tracker: registers one bus-master transaction, publishes it
// to both slave arbiters and walks it through grant, acknowledge and read-data phases.
`timescale 1ns/1ps
module master_req_ctrl #(
  parameter int unsigned SEL_BIT = 31,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_req,
  input  logic        m_cmd,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_ready,
  output logic        m_done,
  output logic        m_err,
  output logic [31:0] m_rdata,
  output logic [1:0]  req_stat,
  output logic        sfor,
  output logic        cmd,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        perm_s0,
  input  logic        perm_s1,
  input  logic        ack_s0,
  input  logic        ack_s1,
  input  logic        rvalid_s0,
  input  logic        rvalid_s1,
  input  logic [31:0] rdata_s0,
  input  logic [31:0] rdata_s1
);

  localparam logic [1:0] NO_REQ = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] W_ACK  = 2'd2;
  localparam logic [1:0] W_DATA = 2'd3;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  stat_q, stat_d;
  logic        sfor_q, sfor_d;
  logic        cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        perm_sel, ack_sel, rvalid_sel;
  logic [31:0] rdata_sel;

  // Only the slave this request targets is listened to; the other one is ignored.
  assign perm_sel   = sfor_q ? perm_s1   : perm_s0;
  assign ack_sel    = sfor_q ? ack_s1    : ack_s0;
  assign rvalid_sel = sfor_q ? rvalid_s1 : rvalid_s0;
  assign rdata_sel  = sfor_q ? rdata_s1  : rdata_s0;

  // Handshake: a request is taken on a rising edge where m_req && m_ready;
  // m_req while m_ready is low is dropped, never queued.
  assign m_ready  = (stat_q == NO_REQ);
  assign m_done   = done_q;
  assign m_err    = err_q;
  assign m_rdata  = rdata_q;
  assign req_stat = stat_q;
  assign sfor     = sfor_q;
  assign cmd      = cmd_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;

  always_comb begin
    stat_d  = stat_q;
    sfor_d  = sfor_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (stat_q)
      NO_REQ: begin
        if (m_req) begin
          stat_d  = WAIT;
          sfor_d  = m_addr[SEL_BIT];
          cmd_d   = m_cmd;
          addr_d  = m_addr;
          wdata_d = m_wdata;
        end
      end
      WAIT: begin
        if (perm_sel) begin
          stat_d = W_ACK;
          cnt_d  = '0;
        end
      end
      W_ACK: begin
        if (ack_sel && (cmd_q || rvalid_sel)) begin
          stat_d = NO_REQ;
          done_d = 1'b1;
          if (!cmd_q) rdata_d = rdata_sel;
        end else if (ack_sel) begin
          stat_d = W_DATA;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          stat_d = NO_REQ;
          done_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      W_DATA: begin
        // The exit event is checked before expiry so it wins a same-cycle tie.
        if (rvalid_sel) begin
          stat_d  = NO_REQ;
          done_d  = 1'b1;
          rdata_d = rdata_sel;
        end else if (cnt_q == CNT_LAST) begin
          stat_d = NO_REQ;
          done_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: stat_d = NO_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q  <= NO_REQ;
      sfor_q  <= 1'b0;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      stat_q  <= stat_d;
      sfor_q  <= sfor_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_master_req_ctrl.sv
// Bench for master_req_ctrl: directed transactions, a phase-level reference model
// compared every cycle, and literal checks at the key points of each scenario.
`timescale 1ns/1ps
module tb_master_req_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req, m_cmd;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready, m_done, m_err;
  logic [31:0] m_rdata;
  logic [1:0]  req_stat;
  logic        sfor, cmd;
  logic [31:0] addr, wdata;
  logic        perm_s0, perm_s1, ack_s0, ack_s1, rvalid_s0, rvalid_s1;
  logic [31:0] rdata_s0, rdata_s1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  master_req_ctrl #(.SEL_BIT(31), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata),
    .req_stat(req_stat), .sfor(sfor), .cmd(cmd), .addr(addr), .wdata(wdata),
    .perm_s0(perm_s0), .perm_s1(perm_s1), .ack_s0(ack_s0), .ack_s1(ack_s1),
    .rvalid_s0(rvalid_s0), .rvalid_s1(rvalid_s1),
    .rdata_s0(rdata_s0), .rdata_s1(rdata_s1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase 0 idle, 1 waiting for grant, 2 waiting for ack, 3 waiting for data.
  // dwell = number of clock edges the request has been sitting in phase 2/3.
  logic [1:0]  exp_stat;
  logic        exp_sfor, exp_cmd, exp_done, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  int          dwell;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    logic p, a, v, leave;
    logic [31:0] rd;
    p  = exp_sfor ? perm_s1   : perm_s0;
    a  = exp_sfor ? ack_s1    : ack_s0;
    v  = exp_sfor ? rvalid_s1 : rvalid_s0;
    rd = exp_sfor ? rdata_s1  : rdata_s0;
    exp_done <= 1'b0;
    exp_err  <= 1'b0;
    if (rst) begin
      exp_stat <= 2'd0; exp_sfor <= 1'b0; exp_cmd <= 1'b0;
      exp_addr <= '0; exp_wdata <= '0; exp_rdata <= '0; dwell <= 0;
    end else if (exp_stat == 2'd0) begin
      if (m_req) begin
        exp_stat <= 2'd1; exp_sfor <= m_addr[31]; exp_cmd <= m_cmd;
        exp_addr <= m_addr; exp_wdata <= m_wdata;
      end
    end else if (exp_stat == 2'd1) begin
      if (p) begin exp_stat <= 2'd2; dwell <= 1; end
    end else begin
      leave = (exp_stat == 2'd2) ? (a && (exp_cmd || v)) : v;
      if (exp_stat == 2'd2 && a && !leave) begin
        exp_stat <= 2'd3; dwell <= 1;
      end else if (leave) begin
        exp_stat <= 2'd0; exp_done <= 1'b1;
        if (!exp_cmd) begin exp_rdata <= rd; exp_q.push_back(rd); end
      end else if (dwell >= TIMEOUT) begin
        exp_stat <= 2'd0; exp_done <= 1'b1; exp_err <= 1'b1;
      end else begin
        dwell <= dwell + 1;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(posedge clk) begin
    #1;
    chk("req_stat", {30'd0, req_stat}, {30'd0, exp_stat});
    chk("m_ready",  {31'd0, m_ready},  {31'd0, exp_stat == 2'd0});
    chk("sfor",     {31'd0, sfor},     {31'd0, exp_sfor});
    chk("cmd",      {31'd0, cmd},      {31'd0, exp_cmd});
    chk("addr",     addr,              exp_addr);
    chk("wdata",    wdata,             exp_wdata);
    chk("m_done",   {31'd0, m_done},   {31'd0, exp_done});
    chk("m_err",    {31'd0, m_err},    {31'd0, exp_err});
    chk("m_rdata",  m_rdata,           exp_rdata);
    if (m_done === 1'b1 && m_err === 1'b0 && cmd === 1'b0) begin
      if (exp_q.size() == 0) chk("read_completion_expected", 32'd1, 32'd0);
      else chk("read_data_queue", m_rdata, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic c, input logic [31:0] a, input logic [31:0] d);
    m_req = 1'b1; m_cmd = c; m_addr = a; m_wdata = d;
    tick();
    m_req = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; m_req = 1'b0; m_cmd = 1'b0; m_addr = '0; m_wdata = '0;
    perm_s0 = 1'b0; perm_s1 = 1'b0; ack_s0 = 1'b0; ack_s1 = 1'b0;
    rvalid_s0 = 1'b0; rvalid_s1 = 1'b0; rdata_s0 = '0; rdata_s1 = '0;
    tick(); tick();
    chk("lit_reset_stat", {30'd0, req_stat}, 32'd0);
    chk("lit_reset_ready", {31'd0, m_ready}, 32'd1);
    chk("lit_reset_rdata", m_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // Write to slave 0, grant two cycles after acceptance.
    req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("lit_w_stat_wait", {30'd0, req_stat}, 32'd1);
    chk("lit_w_sfor", {31'd0, sfor}, 32'd0);
    tick();
    perm_s0 = 1'b1; tick(); perm_s0 = 1'b0;
    chk("lit_w_stat_ack", {30'd0, req_stat}, 32'd2);
    chk("lit_w_wdata", wdata, 32'hDEAD_BEEF);
    ack_s0 = 1'b1; tick(); ack_s0 = 1'b0;
    chk("lit_w_done", {30'd0, req_stat, m_done, m_err}, {28'd0, 2'd0, 1'b1, 1'b0});
    tick();
    chk("lit_w_done_drop", {31'd0, m_done}, 32'd0);

    // Read from slave 1 through the data phase.
    req(1'b0, 32'h8000_0004, 32'h0);
    chk("lit_r_sfor", {31'd0, sfor}, 32'd1);
    perm_s1 = 1'b1; tick(); perm_s1 = 1'b0;
    ack_s1 = 1'b1; tick(); ack_s1 = 1'b0;
    chk("lit_r_stat_data", {30'd0, req_stat}, 32'd3);
    tick();
    rvalid_s1 = 1'b1; rdata_s1 = 32'h1234_5678; tick(); rvalid_s1 = 1'b0;
    chk("lit_r_rdata", m_rdata, 32'h1234_5678);
    chk("lit_r_done", {31'd0, m_done}, 32'd1);
    tick();

    // Wrong-slave isolation, ignored request, then timeout in W_ACK.
    req(1'b1, 32'h8000_0000, 32'h0000_0011);
    perm_s0 = 1'b1; ack_s0 = 1'b1; tick(); perm_s0 = 1'b0; ack_s0 = 1'b0;
    chk("lit_iso_wait", {30'd0, req_stat}, 32'd1);
    perm_s1 = 1'b1; tick(); perm_s1 = 1'b0;
    chk("lit_iso_ack", {30'd0, req_stat}, 32'd2);
    for (int i = 1; i <= TIMEOUT - 1; i++) begin
      if (i == 3) begin ack_s0 = 1'b1; rvalid_s0 = 1'b1; end
      if (i == 4) begin ack_s0 = 1'b0; rvalid_s0 = 1'b0; end
      if (i == 6) begin m_req = 1'b1; m_addr = 32'h0000_0020; end
      if (i == 7) m_req = 1'b0;
      tick();
    end
    chk("lit_to_ack_still", {30'd0, req_stat}, 32'd2);
    tick();
    chk("lit_to_ack_abort", {30'd0, req_stat, m_done, m_err}, {28'd0, 2'd0, 1'b1, 1'b1});
    chk("lit_to_ack_rdata", m_rdata, 32'h1234_5678);
    chk("lit_to_ack_addr", addr, 32'h8000_0000);
    tick();

    // Timeout in W_DATA.
    req(1'b0, 32'h0000_0040, 32'h0);
    perm_s0 = 1'b1; tick(); perm_s0 = 1'b0;
    ack_s0 = 1'b1; tick(); ack_s0 = 1'b0;
    for (int i = 1; i <= TIMEOUT - 1; i++) begin
      if (i == 2) begin rvalid_s1 = 1'b1; rdata_s1 = 32'hFFFF_FFFF; end
      if (i == 3) rvalid_s1 = 1'b0;
      tick();
    end
    chk("lit_to_data_still", {30'd0, req_stat}, 32'd3);
    tick();
    chk("lit_to_data_abort", {31'd0, m_err}, 32'd1);
    chk("lit_to_data_rdata", m_rdata, 32'h1234_5678);
    tick();

    // Ack on the expiry cycle: completion wins over timeout.
    req(1'b1, 32'h0000_0200, 32'h0000_0077);
    perm_s0 = 1'b1; tick(); perm_s0 = 1'b0;
    repeat (TIMEOUT - 1) tick();
    ack_s0 = 1'b1; tick(); ack_s0 = 1'b0;
    chk("lit_tie_done", {30'd0, m_done, m_err}, {30'd0, 1'b1, 1'b0});
    tick();

    // Same-cycle ack+rvalid read, then back-to-back write accepted in the done cycle.
    req(1'b0, 32'h0000_0100, 32'h0);
    perm_s0 = 1'b1; tick(); perm_s0 = 1'b0;
    ack_s0 = 1'b1; rvalid_s0 = 1'b1; rdata_s0 = 32'hA5A5_A5A5;
    tick();
    ack_s0 = 1'b0; rvalid_s0 = 1'b0;
    chk("lit_fast_rdata", m_rdata, 32'hA5A5_A5A5);
    chk("lit_fast_stat", {30'd0, req_stat}, 32'd0);
    req(1'b1, 32'h8000_0008, 32'h0000_0055);
    chk("lit_b2b_stat", {30'd0, req_stat}, 32'd1);
    perm_s1 = 1'b1; tick(); perm_s1 = 1'b0;
    ack_s1 = 1'b1; tick(); ack_s1 = 1'b0;
    chk("lit_b2b_done", {31'd0, m_done}, 32'd1);
    tick();

    // Reset while in W_DATA, then a normal transaction.
    req(1'b0, 32'h8000_0010, 32'h0);
    perm_s1 = 1'b1; tick(); perm_s1 = 1'b0;
    ack_s1 = 1'b1; tick(); ack_s1 = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("lit_rst_stat", {30'd0, req_stat, m_done}, 32'd0);
    chk("lit_rst_addr", addr, 32'd0);
    chk("lit_rst_rdata", m_rdata, 32'd0);
    req(1'b1, 32'h0000_0004, 32'h0000_0099);
    chk("lit_post_rst_addr", addr, 32'h0000_0004);
    perm_s0 = 1'b1; tick(); perm_s0 = 1'b0;
    ack_s0 = 1'b1; tick(); ack_s0 = 1'b0;
    chk("lit_post_rst_done", {31'd0, m_done}, 32'd1);
    tick(); tick();

    chk("read_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/master_req_ctrl.md
Name: master_req_ctrl

Overview:
Per-master request tracker that sits directly upstream of each slave's round-robin request arbiter. It accepts one transaction at a time from a bus master and registers it. It decodes the target slave and publishes req_stat/sfor/cmd/addr/wdata to the arbiters. It then walks the request through permission, acknowledge and read-data phases, with a watchdog timeout. One instance per master; both slave arbiters see every instance's outputs.

Parameters:
SEL_BIT, 31, address bit that selects the target slave (0 = slave 0, 1 = slave 1)
TIMEOUT, 16, max cycles spent in W_ACK or W_DATA before abort; legal range 2..255

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
m_req  in  1  master request strobe, sampled only when m_ready=1
m_cmd  in  1  1 = write, 0 = read
m_addr  in  32  request address
m_wdata  in  32  write data
m_ready  out  1  combinational, high iff req_stat==NO_REQ
m_done  out  1  one-cycle pulse on completion or abort
m_err  out  1  valid with m_done; 1 = timeout abort
m_rdata  out  32  read data, valid with m_done for reads, held until next read completes
req_stat  out  2  NO_REQ=0, WAIT=1, W_ACK=2, W_DATA=3 (arbiter encoding)
sfor  out  1  target slave, registered m_addr[SEL_BIT]
cmd  out  1  registered m_cmd
addr  out  32  registered m_addr
wdata  out  32  registered m_wdata
perm_s0, perm_s1  in  1  grant for this master from slave 0 / slave 1 arbiter
ack_s0, ack_s1  in  1  request acknowledge from slave 0 / 1
rvalid_s0, rvalid_s1  in  1  read data valid from slave 0 / 1
rdata_s0, rdata_s1  in  32  read data from slave 0 / 1

Behaviour:
- Reset (rst=1 at edge): req_stat=NO_REQ, sfor=0, cmd=0, addr=0, wdata=0, m_done=0, m_err=0, m_rdata=0, timeout counter=0. Reset mid-transaction drops the request silently; no m_done.
- Selected inputs: perm=sfor?perm_s1:perm_s0; ack, rvalid and rdata are selected the same way. Signals from the non-selected slave are ignored in every state.
- NO_REQ: if m_req, register cmd/addr/wdata, set sfor=m_addr[SEL_BIT], go to WAIT next cycle. m_req while m_ready=0 is ignored (no queueing).
- WAIT: hold all registered outputs. On perm, go to W_ACK and clear the counter. ack/rvalid in WAIT are ignored. There is no timeout in WAIT; the arbiter guarantees eventual grant.
- W_ACK: on ack with cmd=1, go to NO_REQ; m_done=1, m_err=0.
- W_ACK: on ack with cmd=0 and rvalid in the same cycle, go to NO_REQ; capture m_rdata and pulse m_done.
- W_ACK: on ack with cmd=0 and no rvalid, go to W_DATA and clear the counter.
- W_DATA: on rvalid, capture m_rdata=rdata, go to NO_REQ, m_done=1, m_err=0.
- Timeout: the counter increments each cycle in W_ACK/W_DATA without the exit event. When the counter reaches TIMEOUT-1 and no exit event occurs, go to NO_REQ with m_done=1, m_err=1; m_rdata is unchanged. If the exit event and expiry fall in the same cycle, the exit event wins.
- m_done/m_err are registered: asserted in the cycle req_stat becomes NO_REQ, low otherwise.
- Back-to-back: m_ready is high in the m_done cycle, so a new m_req is accepted then. Minimum write turnaround is 3 cycles (WAIT, W_ACK, NO_REQ).
- Registered outputs change only on NO_REQ->WAIT acceptance, so they remain stable while the arbiter samples them.

Test Plan:
- Write to slave 0: m_req, m_cmd=1, m_addr=0x0000_0010, m_wdata=0xDEAD_BEEF; perm_s0 after 2 cycles, ack_s0 after 1 more -> stat 0→1→2→0; sfor=0; addr/wdata held; m_done=1, m_err=0 for exactly one cycle.
- Read from slave 1: m_addr=0x8000_0004, m_cmd=0; perm_s1, then ack_s1, then rvalid_s1 with rdata_s1=0x1234_5678 two cycles later -> stat 1→2→3→0; sfor=1; m_rdata=0x1234_5678 with m_done.
- Wrong-slave isolation: sfor=1, pulse perm_s0/ack_s0 -> stat stays WAIT; then perm_s1 -> W_ACK.
- Timeout: grant given, ack never arrives, TIMEOUT=16 -> exactly 16 cycles in W_ACK, then stat=0, m_done=1, m_err=1, m_rdata unchanged; a second timeout in W_DATA gives the same result.
- Ignored request plus same-cycle ack/rvalid read: m_req pulsed during W_ACK -> no effect. Read where ack_s0 and rvalid_s0 (rdata=0xA5A5_A5A5) coincide -> skips W_DATA, m_rdata=0xA5A5_A5A5.
- Reset mid-op: rst=1 while in W_DATA -> all outputs at reset values next cycle, no m_done; a new m_req after reset is accepted normally.
